storebyte_rmw: RTL and testbench
================================

// Module: storebyte_rmw
// PURPOSE
//  Store-side counterpart of the load-path byte/halfword extractor. Accepts one store (word/half/byte)
//  from the MEM stage and writes it into a word-only data memory (no byte enables at the RAM).
//  Sub-word stores run read-modify-write: read the word, merge the lane(s), write the word back.
//  Sits between the MEM-stage store request and the data RAM port. One store in flight at a time.
// PARAMETERS
//  ADDR_W   32   byte-address width of addr; mem_addr is ADDR_W-2 bits (word address)
// PORTS
//  clk        in   1         single clock, all state on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   1         store request present; addr/LSOp/WD_in are valid while high
//  req_ready  out  1         block can accept a request this cycle (1 only in IDLE)
//  addr       in   ADDR_W    byte address of the store
//  LSOp       in   2         11 word, 10 half, 01 byte, 00 treated as word
//  WD_in      in   32        store data, right-aligned (byte in [7:0], half in [15:0])
//  done       out  1         one-cycle pulse in the cycle the memory write is issued
//  busy       out  1         high in every state except IDLE
//  mem_addr   out  ADDR_W-2  word address to data RAM (addr[ADDR_W-1:2] captured at accept)
//  mem_re     out  1         RAM read strobe; mem_rdata valid the following cycle
//  mem_rdata  in   32        RAM read data
//  mem_we     out  1         RAM write strobe (full word)
//  mem_wdata  out  32        full word to write
//  mem_be     out  4         lanes being modified (debug/trace only; RAM ignores it)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; req_ready=1; done=0, busy=0, mem_re=0, mem_we=0;
//   mem_addr=0, mem_wdata=0, mem_be=0; capture regs cleared. Applies immediately, mid-op included.
//  FSM states: IDLE, READ, WAIT, WRITE.
//   IDLE : req_ready=1. If req_valid: capture addr, LSOp, WD_in. LSOp in {11,00} -> WRITE; else -> READ.
//   READ : mem_re=1, mem_addr=captured word addr. -> WAIT unconditionally.
//   WAIT : mem_rdata valid; register merged word = mem_rdata with selected lanes replaced. -> WRITE.
//   WRITE: mem_we=1, mem_wdata=merged word (or captured WD_in for word ops), done=1. -> IDLE.
//  Merge rules (lane k = bits [8k+7:8k]):
//   byte: lane addr[1:0] <= WD_in[7:0]; mem_be = 1<<addr[1:0].
//   half: addr[1]=0 -> lanes 0,1 <= WD_in[15:0], be=0011; addr[1]=1 -> lanes 2,3 <= WD_in[15:0], be=1100.
//         addr[0] ignored (same lane selection as the load extractor); no misalignment trap here.
//   word: mem_wdata=WD_in, be=1111; addr[1:0] ignored.
//  Latency (accept edge to write cycle): word 1 cycle (write in cycle after accept), sub-word 3 cycles.
//   req_ready is low from the cycle after accept until IDLE is re-entered (next cycle after WRITE).
//  Handshake: transfer occurs on rising edge with req_valid & req_ready. Inputs sampled only then;
//   changes to addr/LSOp/WD_in while busy have no effect. Back-to-back stores: new request accepted
//   in the IDLE cycle following WRITE (one-cycle bubble minimum).
//  mem_re and mem_we are never high in the same cycle; each is high for exactly one cycle per store.
//  mem_addr holds the captured word address from accept until the next accept (stable through WRITE).
//  mem_be valid READ..WRITE, 0 in IDLE. mem_wdata is 0 outside WRITE.
//  Reset asserted in READ/WAIT: no write issued, done never pulses for that store; RAM keeps old data.
//  Reset asserted in WRITE: write strobe drops asynchronously; RAM outcome is the RAM's concern.
// TESTING
//  1 Word: RAM[0x10]=0xDEADBEEF; store LSOp=11 addr=0x40 WD=0x12345678 -> mem_we 1 cycle after
//    accept, mem_addr=0x10, mem_wdata=0x12345678, no mem_re, done pulse with mem_we.
//  2 Byte sweep: RAM word=0xAABBCCDD; LSOp=01 WD=0x000000EE at addr[1:0]=0,1,2,3 (fresh word each)
//    -> written 0xAABBCCEE, 0xAABBEEDD, 0xAAEECCDD, 0xEEBBCCDD; mem_be=0001/0010/0100/1000; 3-cycle latency.
//  3 Half: RAM=0x11223344; LSOp=10 WD=0xFFFF5566 addr[1:0]=2 -> 0x55663344; addr[1:0]=1 -> 0x11225566
//    (upper WD bits ignored, addr[0] ignored).
//  4 Back-to-back: req_valid held high with byte then word store -> second accepted the cycle after the
//    first's WRITE; req_ready=0 and input changes ignored while busy; both writes correct, two done pulses.
//  5 Reset mid-op: assert rst_n=0 during WAIT of a byte store -> all outputs to reset values at once,
//    no mem_we, no done; after release, req_ready=1 and a new word store completes normally.
//  6 LSOp=00 addr=0x3 WD=0xCAFEF00D -> handled as word: mem_wdata=0xCAFEF00D, mem_addr=0x0, be=1111.

Source files
------------

// File: rtl/storebyte_rmw.sv
// storebyte_rmw: store path into a word-only data RAM.
// Word stores are written directly; byte and halfword stores read the
// addressed word, merge the new lane(s) in, and write the whole word back.
// Only one store is in flight at a time.

module storebyte_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        LSOp,
  input  logic [31:0]       WD_in,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    WRITE
  } state_t;

  localparam logic [1:0] OP_BYTE = 2'b01;
  localparam logic [1:0] OP_HALF = 2'b10;

  state_t            state;
  state_t            next_state;

  // Captured request; word_q first holds the store data, then the merged word.
  logic [ADDR_W-3:0] addr_q;
  logic [1:0]        lane_q;
  logic [1:0]        op_q;
  logic [3:0]        be_q;
  logic [31:0]       word_q;

  logic              accept;
  logic              is_subword;
  logic [3:0]        be_next;
  logic [31:0]       merged;

  assign accept     = (state == IDLE) && req_valid;
  assign is_subword = (LSOp == OP_BYTE) || (LSOp == OP_HALF);

  // Lane mask for the incoming request; opcode 00 behaves like a word store.
  always_comb begin
    be_next = 4'b1111;
    if (LSOp == OP_BYTE) begin
      be_next = 4'b0001 << addr[1:0];
    end else if (LSOp == OP_HALF) begin
      be_next = addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Replace the selected lane(s) of the RAM word with the right-aligned store data.
  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_BYTE) begin
      case (lane_q)
        2'd0:    merged[7:0]   = word_q[7:0];
        2'd1:    merged[15:8]  = word_q[7:0];
        2'd2:    merged[23:16] = word_q[7:0];
        default: merged[31:24] = word_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = word_q[15:0];
    end else begin
      merged[15:0]  = word_q[15:0];
    end
  end

  // State register; reset returns to IDLE immediately, even mid-store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the request on accept and fold in the RAM word during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      lane_q <= '0;
      op_q   <= '0;
      be_q   <= '0;
      word_q <= '0;
    end else if (accept) begin
      addr_q <= addr[ADDR_W-1:2];
      lane_q <= addr[1:0];
      op_q   <= LSOp;
      be_q   <= be_next;
      word_q <= WD_in;
    end else if (state == WAIT) begin
      word_q <= merged;
    end
  end

  // Next-state and output decode; all outputs derive from state and captured regs.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    mem_wdata  = '0;
    mem_be     = be_q;
    mem_addr   = addr_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        mem_be    = '0;
        if (req_valid) begin
          next_state = is_subword ? READ : WRITE;
        end
      end
      READ: begin
        mem_re     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        next_state = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        done       = 1'b1;
        mem_wdata  = word_q;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_storebyte_rmw.sv
// tb_storebyte_rmw: directed checks of storebyte_rmw against a small
// registered-read RAM model, with hand-computed expected words.

module tb_storebyte_rmw;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [1:0]  LSOp;
  logic [31:0] WD_in;
  logic        done;
  logic        busy;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  logic [31:0] ram [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int n_assert = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int done_cnt = 0;
  int both_cnt = 0;

  storebyte_rmw #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr      (addr),
    .LSOp      (LSOp),
    .WD_in     (WD_in),
    .done      (done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears the cycle after mem_re; preload port for setup.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_idx] <= pl_data;
    end else if (mem_we) begin
      ram[mem_addr[5:0]] <= mem_wdata;
    end
    if (mem_re) begin
      mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  // Strobe counters across the whole run.
  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [1:0] op, input logic [31:0] wd);
    req_valid = v;
    addr      = a;
    LSOp      = op;
    WD_in     = wd;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // One isolated store, checked cycle by cycle from accept through the return to IDLE.
  task automatic runStore(input string name, input logic [31:0] a, input logic [1:0] op,
                          input logic [31:0] wd, input bit sub, input logic [29:0] widx,
                          input logic [31:0] exp_word, input logic [3:0] exp_be);
    @(negedge clk);
    checkOutput({name, " ready_idle"}, {31'd0, req_ready}, 32'd1);
    applyStimulus(1'b1, a, op, wd);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'b00, 32'h0);
    if (sub) begin
      checkOutput({name, " re_read"}, {31'd0, mem_re}, 32'd1);
      checkOutput({name, " we_read"}, {31'd0, mem_we}, 32'd0);
      checkOutput({name, " ready_read"}, {31'd0, req_ready}, 32'd0);
      checkOutput({name, " addr_read"}, {2'b00, mem_addr}, {2'b00, widx});
      @(negedge clk);
      checkOutput({name, " re_wait"}, {31'd0, mem_re}, 32'd0);
      checkOutput({name, " busy_wait"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    checkOutput({name, " we"}, {31'd0, mem_we}, 32'd1);
    checkOutput({name, " done"}, {31'd0, done}, 32'd1);
    checkOutput({name, " re_write"}, {31'd0, mem_re}, 32'd0);
    checkOutput({name, " wdata"}, mem_wdata, exp_word);
    checkOutput({name, " addr"}, {2'b00, mem_addr}, {2'b00, widx});
    checkOutput({name, " be"}, {28'd0, mem_be}, {28'd0, exp_be});
    @(negedge clk);
    checkOutput({name, " we_after"}, {31'd0, mem_we}, 32'd0);
    checkOutput({name, " wdata_idle"}, mem_wdata, 32'd0);
    checkOutput({name, " be_idle"}, {28'd0, mem_be}, 32'd0);
    checkOutput({name, " ram"}, ram[widx[5:0]], exp_word);
  endtask

  initial begin
    logic [31:0] byte_exp [0:3];
    logic [3:0]  byte_be  [0:3];
    int          we_before;

    byte_exp[0] = 32'hAABBCCEE; byte_be[0] = 4'b0001;
    byte_exp[1] = 32'hAABBEEDD; byte_be[1] = 4'b0010;
    byte_exp[2] = 32'hAAEECCDD; byte_be[2] = 4'b0100;
    byte_exp[3] = 32'hEEBBCCDD; byte_be[3] = 4'b1000;

    rst_n = 1'b0;
    pl_en = 1'b0;
    pl_idx = '0;
    pl_data = '0;
    applyStimulus(1'b0, 32'h0, 2'b00, 32'h0);

    // Reset values
    #12;
    checkOutput("rst ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst done", {31'd0, done}, 32'd0);
    checkOutput("rst re", {31'd0, mem_re}, 32'd0);
    checkOutput("rst we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst addr", {2'b00, mem_addr}, 32'd0);
    checkOutput("rst wdata", mem_wdata, 32'd0);
    checkOutput("rst be", {28'd0, mem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store
    preload(6'd16, 32'hDEADBEEF);
    runStore("word", 32'h40, 2'b11, 32'h12345678, 1'b0, 30'h10, 32'h12345678, 4'b1111);

    // Byte sweep over all four lanes
    for (int i = 0; i < 4; i++) begin
      preload(6'd4, 32'hAABBCCDD);
      runStore($sformatf("byte%0d", i), 32'h10 + i, 2'b01, 32'h000000EE, 1'b1, 30'h4,
               byte_exp[i], byte_be[i]);
    end

    // Halfword stores, upper data and addr[0] ignored
    preload(6'd5, 32'h11223344);
    runStore("half_hi", 32'h16, 2'b10, 32'hFFFF5566, 1'b1, 30'h5, 32'h55663344, 4'b1100);
    preload(6'd5, 32'h11223344);
    runStore("half_lo", 32'h15, 2'b10, 32'hFFFF5566, 1'b1, 30'h5, 32'h11225566, 4'b0011);

    // Back-to-back: valid held high, inputs switch to a word store while busy
    preload(6'd8, 32'h01020304);
    preload(6'd9, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h21, 2'b01, 32'h000000AB);
    @(negedge clk);
    applyStimulus(1'b1, 32'h24, 2'b11, 32'h55AA55AA);
    checkOutput("b2b ready_busy", {31'd0, req_ready}, 32'd0);
    checkOutput("b2b addr_read", {2'b00, mem_addr}, 32'h8);
    checkOutput("b2b be_read", {28'd0, mem_be}, 32'h2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2b first_we", {31'd0, mem_we}, 32'd1);
    checkOutput("b2b first_wdata", mem_wdata, 32'h0102AB04);
    checkOutput("b2b first_addr", {2'b00, mem_addr}, 32'h8);
    @(negedge clk);
    checkOutput("b2b ready_bubble", {31'd0, req_ready}, 32'd1);
    checkOutput("b2b we_bubble", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'b00, 32'h0);
    checkOutput("b2b second_we", {31'd0, mem_we}, 32'd1);
    checkOutput("b2b second_done", {31'd0, done}, 32'd1);
    checkOutput("b2b second_wdata", mem_wdata, 32'h55AA55AA);
    checkOutput("b2b second_addr", {2'b00, mem_addr}, 32'h9);
    checkOutput("b2b second_be", {28'd0, mem_be}, 32'hF);
    @(negedge clk);
    checkOutput("b2b ram8", ram[8], 32'h0102AB04);
    checkOutput("b2b ram9", ram[9], 32'h55AA55AA);

    // Reset during WAIT of a byte store
    preload(6'd12, 32'h77777777);
    @(negedge clk);
    applyStimulus(1'b1, 32'h30, 2'b01, 32'h00000011);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    checkOutput("abort in_wait", {31'd0, busy}, 32'd1);
    we_before = we_cnt;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort ready", {31'd0, req_ready}, 32'd1);
    checkOutput("abort we", {31'd0, mem_we}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort addr", {2'b00, mem_addr}, 32'd0);
    checkOutput("abort be", {28'd0, mem_be}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort no_write", we_cnt, we_before);
    checkOutput("abort ram", ram[12], 32'h77777777);
    rst_n = 1'b1;
    runStore("post_rst", 32'h34, 2'b11, 32'h0BADCAFE, 1'b0, 30'hD, 32'h0BADCAFE, 4'b1111);

    // Opcode 00 treated as a word store, low address bits ignored
    preload(6'd0, 32'h0);
    runStore("op00", 32'h3, 2'b00, 32'hCAFEF00D, 1'b0, 30'h0, 32'hCAFEF00D, 4'b1111);

    // Strobe totals over the run
    @(negedge clk);
    checkOutput("total we", we_cnt, 11);
    checkOutput("total re", re_cnt, 8);
    checkOutput("total done", done_cnt, 11);
    checkOutput("re_we overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
